ysyx_22041211_alu_arbiter: RTL and testbench
============================================

Name: ysyx_22041211_alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the EXU main path, port 1 is the branch/compare unit.
- Provides round-robin arbitration, per-port valid/ready request and response handshakes, and an operand/result register stage so the ALU always sees stable inputs.
- Sits between the requesters and the ALU instance; it drives the ALU operand and opcode inputs and samples its result and flag outputs.

Parameters:
- DATA_LEN, 32, operand/result width.
- OP_LEN, 4, ALU opcode width; must match the ALU alu_control width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src1  in  DATA_LEN  requester 0 operand 1.
- req0_src2  in  DATA_LEN  requester 0 operand 2.
- req0_op  in  OP_LEN  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_src1, req1_src2, req1_op  same as port 0, for requester 1.
- resp0_valid  out  1  requester 0 result available.
- resp0_ready  in  1  requester 0 consumes the result.
- resp0_result  out  DATA_LEN  requester 0 result.
- resp0_less  out  1  requester 0 less/borrow flag.
- resp0_zero  out  1  requester 0 zero flag.
- resp1_valid, resp1_ready, resp1_result, resp1_less, resp1_zero  same as port 0, for requester 1.
- alu_src1  out  DATA_LEN  to ALU src1.
- alu_src2  out  DATA_LEN  to ALU src2.
- alu_control  out  OP_LEN  to ALU alu_control.
- alu_result  in  DATA_LEN  from ALU result.
- alu_less  in  1  from ALU alu_less_o.
- alu_zero  in  1  from ALU alu_zero_o.

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE. Reset forces IDLE.
- IDLE:
  - Grant: if only one reqN_valid is high, grant N. If both are high, grant the port named by the prio register.
  - reqN_ready is combinational and high only in IDLE, only for the granted port. At most one req_ready is high per cycle.
  - On grant: latch src1, src2, op into the operand registers and the granted id into gid; go to EXEC.
- EXEC:
  - alu_src1/alu_src2/alu_control are driven from the operand registers; they are stable the whole cycle.
  - At the end of the cycle, latch alu_result, alu_less, alu_zero into the result registers; go to RESP.
- RESP:
  - respN_valid is high for N == gid only; the other port's resp_valid stays 0.
  - Result and flag outputs hold stable until the handshake. respN_valid and respN_ready both high ends the transaction.
  - On the handshake: prio <= ~gid; go to IDLE.
  - No new request is accepted in EXEC or RESP; all req_ready are 0.
- Latency: accept at cycle T; resp_valid first high at T+2. Peak throughput is 1 operation per 3 cycles.
- Requester rule: reqN_src1/src2/op must be held stable while valid is high and ready is low. The arbiter only samples them in the accept cycle.
- Opcode is passed through unchecked. Unknown opcodes yield whatever the ALU default produces (result 0).
- alu_* outputs always reflect the operand registers, including in IDLE and RESP.
- resp_result/less/zero always reflect the result registers. They are meaningful only while the matching resp_valid is high.
- Reset values: state=IDLE, prio=0, gid=0, operand registers=0, result registers=0. All req_ready=0 and all resp_valid=0.
- Reset mid-operation (in EXEC or RESP): the transaction is dropped with no response, and the operand and result registers are cleared. The requester must reissue.
- Simultaneous events:
  - A requester deasserting valid in the same cycle it is granted cannot happen, because ready is combinational from valid.
  - resp_ready high outside RESP is ignored.
- Fairness: both ports continuously valid alternate grants 0,1,0,1, starting with 0 after reset.
- No bypass: a response handshake and a new accept never occur in the same cycle.

Test Plan:
- Req0 only, src1=5, src2=3, op=ALU_OP_ADD, resp0_ready=1 -> req0_ready high in cycle T; resp0_valid high in cycle T+2 with result=8, less=0, zero=0; resp1_valid stays 0.
- Both valid right after reset: req0 ADD 1+1; req1 SUB 7-7 -> req0 is granted first; then req1 gives resp1_result=0, zero=1.
- Backpressure: hold resp1_ready=0 for 5 cycles while req0_valid=1 -> resp1_valid, result and flags stay constant; req0_ready=0 throughout; req0 is granted in the first IDLE cycle after the handshake.
- Both requesters continuously valid for 6 operations -> grant order 0,1,0,1,0,1; each operation spans exactly 3 cycles with resp_ready tied high.
- Signed compare: src1=0xFFFFFFFF, src2=0x00000001, op=ALU_OP_LESS_SIGNED -> result=1, less=1. Same operands with ALU_OP_LESS_UNSIGNED -> result=0, less=0.
- Assert reset during EXEC -> the next cycle is IDLE with all resp_valid=0 and prio=0; no response is ever produced for the dropped operation.

Source files
------------

// File: rtl/ysyx_22041211_alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the EXU main
// path (port 0) and the branch/compare unit (port 1). Each transaction passes
// through IDLE (accept) -> EXEC (ALU evaluates registered operands) -> RESP
// (result held until the requester takes it).
module ysyx_22041211_alu_arbiter #(
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned OP_LEN   = 4
) (
   input  logic                clock,
   input  logic                reset,
   // Requester 0
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [DATA_LEN-1:0] req0_src1,
   input  logic [DATA_LEN-1:0] req0_src2,
   input  logic [OP_LEN-1:0]   req0_op,
   // Requester 1
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [DATA_LEN-1:0] req1_src1,
   input  logic [DATA_LEN-1:0] req1_src2,
   input  logic [OP_LEN-1:0]   req1_op,
   // Response 0
   output logic                resp0_valid,
   input  logic                resp0_ready,
   output logic [DATA_LEN-1:0] resp0_result,
   output logic                resp0_less,
   output logic                resp0_zero,
   // Response 1
   output logic                resp1_valid,
   input  logic                resp1_ready,
   output logic [DATA_LEN-1:0] resp1_result,
   output logic                resp1_less,
   output logic                resp1_zero,
   // Shared ALU
   output logic [DATA_LEN-1:0] alu_src1,
   output logic [DATA_LEN-1:0] alu_src2,
   output logic [OP_LEN-1:0]   alu_control,
   input  logic [DATA_LEN-1:0] alu_result,
   input  logic                alu_less,
   input  logic                alu_zero
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e              state_q, state_d;
   logic                prio_q, prio_d;
   logic                gid_q, gid_d;
   logic [DATA_LEN-1:0] src1_q, src1_d;
   logic [DATA_LEN-1:0] src2_q, src2_d;
   logic [OP_LEN-1:0]   op_q, op_d;
   logic [DATA_LEN-1:0] result_q, result_d;
   logic                less_q, less_d;
   logic                zero_q, zero_d;

   logic any_valid;
   logic grant;
   logic resp_fire;

   // A lone requester always wins; on contention the prio bit picks the port.
   assign any_valid = req0_valid | req1_valid;
   assign grant     = (req0_valid & req1_valid) ? prio_q : req1_valid;
   assign resp_fire = gid_q ? resp1_ready : resp0_ready;

   // The ALU only ever sees registered operands, so its inputs never glitch.
   assign alu_src1    = src1_q;
   assign alu_src2    = src2_q;
   assign alu_control = op_q;

   assign resp0_result = result_q;
   assign resp0_less   = less_q;
   assign resp0_zero   = zero_q;
   assign resp1_result = result_q;
   assign resp1_less   = less_q;
   assign resp1_zero   = zero_q;

   // Next-state, register-load and handshake decode for the three-phase FSM.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      gid_d       = gid_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      op_d        = op_q;
      result_d    = result_q;
      less_d      = less_q;
      zero_d      = zero_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;

      case (state_q)
         StIdle: begin
            if (any_valid) begin
               req0_ready = ~grant;
               req1_ready = grant;
               gid_d      = grant;
               src1_d     = grant ? req1_src1 : req0_src1;
               src2_d     = grant ? req1_src2 : req0_src2;
               op_d       = grant ? req1_op : req0_op;
               state_d    = StExec;
            end
         end
         StExec: begin
            result_d = alu_result;
            less_d   = alu_less;
            zero_d   = alu_zero;
            state_d  = StResp;
         end
         StResp: begin
            resp0_valid = ~gid_q;
            resp1_valid = gid_q;
            if (resp_fire) begin
               // Hand priority to the port that did not just finish.
               prio_d  = ~gid_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         prio_q   <= 1'b0;
         gid_q    <= 1'b0;
         src1_q   <= '0;
         src2_q   <= '0;
         op_q     <= '0;
         result_q <= '0;
         less_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         gid_q    <= gid_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         op_q     <= op_d;
         result_q <= result_d;
         less_q   <= less_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_alu_arbiter.sv
// Scoreboard bench for the ALU arbiter: drivers push the expected response at
// the accept cycle, a negedge monitor pops and compares on every handshake.
module tb_ysyx_22041211_alu_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned OW = 4;

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpLts = 4'd2;
   localparam logic [3:0] OpLtu = 4'd3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
   logic [OW-1:0] req0_op, req1_op;
   logic          resp0_valid, resp0_ready, resp0_less, resp0_zero;
   logic          resp1_valid, resp1_ready, resp1_less, resp1_zero;
   logic [DW-1:0] resp0_result, resp1_result;
   logic [DW-1:0] alu_src1, alu_src2, alu_result;
   logic [OW-1:0] alu_control;
   logic          alu_less, alu_zero;

   logic          rand_rdy, want0, want1, rnd0, rnd1;

   always #5 clock = ~clock;

   assign resp0_ready = rand_rdy ? rnd0 : want0;
   assign resp1_ready = rand_rdy ? rnd1 : want1;

   ysyx_22041211_alu_arbiter #(.DATA_LEN(DW), .OP_LEN(OW)) dut (
      .clock       (clock),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_src1   (req0_src1),
      .req0_src2   (req0_src2),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_src1   (req1_src1),
      .req1_src2   (req1_src2),
      .req1_op     (req1_op),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp0_result(resp0_result),
      .resp0_less  (resp0_less),
      .resp0_zero  (resp0_zero),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp1_result(resp1_result),
      .resp1_less  (resp1_less),
      .resp1_zero  (resp1_zero),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_less    (alu_less),
      .alu_zero    (alu_zero)
   );

   // Behavioural ALU: returns {result, less, zero}; unknown opcodes give 0.
   function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      logic        l;
      r = 32'd0;
      l = 1'b0;
      case (op)
         OpAdd: r = a + b;
         OpSub: begin r = a - b; l = (a < b); end
         OpLts: begin l = ($signed(a) < $signed(b)); r = {31'd0, l}; end
         OpLtu: begin l = (a < b); r = {31'd0, l}; end
         default: r = 32'd0;
      endcase
      return {r, l, (r == 32'd0)};
   endfunction

   assign {alu_result, alu_less, alu_zero} = alu_ref(alu_control, alu_src1, alu_src2);

   typedef struct packed {
      logic [33:0] e;
      int          t;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   glog[$];
   int   gcyc[$];
   int   cyc = 0;
   int   hs_cyc[2];
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endfunction

   function automatic int qsize(input int p);
      return (p == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int p);
      return (p == 0) ? q0[0] : q1[0];
   endfunction

   function automatic exp_t qpop(input int p);
      return (p == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   // Monitor: latency, hold-under-backpressure and data checks per port.
   logic        pv[2];
   logic        pr[2];
   logic [33:0] pval[2];
   always @(negedge clock) begin
      logic        v, r;
      logic [33:0] val;
      exp_t        x;
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0;
            pr[p] = 1'b0;
            pval[p] = '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            v   = (p == 0) ? resp0_valid : resp1_valid;
            r   = (p == 0) ? resp0_ready : resp1_ready;
            val = (p == 0) ? {resp0_result, resp0_less, resp0_zero}
                           : {resp1_result, resp1_less, resp1_zero};
            if (v && !pv[p]) begin
               chk((p == 0) ? "resp0_expected" : "resp1_expected", 64'(qsize(p) != 0), 1);
               if (qsize(p) != 0) begin
                  x = qfront(p);
                  chk((p == 0) ? "resp0_latency" : "resp1_latency", 64'(cyc - x.t), 2);
               end
            end
            if (v && pv[p] && !pr[p]) chk((p == 0) ? "resp0_hold" : "resp1_hold", val, pval[p]);
            if (v && r && qsize(p) != 0) begin
               x = qpop(p);
               chk((p == 0) ? "resp0_data" : "resp1_data", val, x.e);
               hs_cyc[p] = cyc;
            end
            pv[p] = v;
            pr[p] = r;
            pval[p] = val;
         end
         chk("req_ready_onehot", 64'(req0_ready & req1_ready), 0);
         chk("resp_valid_onehot", 64'(resp0_valid & resp1_valid), 0);
         chk("no_bypass", 64'((req0_ready | req1_ready) & (resp0_valid | resp1_valid)), 0);
      end
   end

   // Present one request and hold it until accepted; push expectation at accept.
   task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [33:0] e);
      exp_t x;
      if (p == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if ((p == 0) ? req0_ready : req1_ready) begin
            x.e = e;
            x.t = cyc;
            if (p == 0) q0.push_back(x);
            else        q1.push_back(x);
            glog.push_back(p);
            gcyc.push_back(cyc);
            @(posedge clock);
            #1;
            if (p == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
            return;
         end
      end
      chk((p == 0) ? "req0_accept_timeout" : "req1_accept_timeout", 64'(cyc), 64'(-1));
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 100; c++) begin
         if (q0.size() == 0 && q1.size() == 0) return;
         @(posedge clock);
         #1;
      end
      chk("drain_timeout", 64'(q0.size() + q1.size()), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      q0.delete();
      q1.delete();
      glog.delete();
      gcyc.delete();
   endtask

   task automatic rand_port(input int p);
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 15; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
         op = 4'($urandom_range(0, 5));
         if (op > 4'd3) op = 4'($urandom_range(4, 15));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = $urandom_range(0, 3);
            default: b = $urandom;
         endcase
         issue(p, op, a, b, alu_ref(op, a, b));
      end
   endtask

   initial begin
      rnd0 = 1'b1;
      rnd1 = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         rnd0 = ($urandom_range(0, 3) != 0);
         rnd1 = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_op = '0;
      req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_op = '0;
      want0 = 1'b0; want1 = 1'b0; rand_rdy = 1'b0;
      hs_cyc[0] = 0; hs_cyc[1] = 0;

      do_reset();
      chk("rst_req0_ready", 64'(req0_ready), 0);
      chk("rst_req1_ready", 64'(req1_ready), 0);
      chk("rst_resp0_valid", 64'(resp0_valid), 0);
      chk("rst_resp1_valid", 64'(resp1_valid), 0);
      chk("rst_alu_ops", {alu_src1, alu_src2}, 0);
      chk("rst_alu_control", 64'(alu_control), 0);
      chk("rst_result", {resp0_result, resp0_less, resp0_zero}, 0);

      // Single requester, add.
      want0 = 1'b1;
      issue(0, OpAdd, 32'd5, 32'd3, {32'd8, 1'b0, 1'b0});
      drain();

      // Signed vs unsigned compare on port 1.
      want1 = 1'b1;
      issue(1, OpLts, 32'hFFFF_FFFF, 32'd1, {32'd1, 1'b1, 1'b0});
      issue(1, OpLtu, 32'hFFFF_FFFF, 32'd1, {32'd0, 1'b0, 1'b1});
      drain();

      // Backpressure on port 1 while port 0 waits.
      want1 = 1'b0;
      issue(1, OpSub, 32'd3, 32'd9, {32'hFFFF_FFFA, 1'b1, 1'b0});
      fork
         issue(0, OpAdd, 32'd100, 32'd23, {32'd123, 1'b0, 1'b0});
         begin
            for (int c = 0; c < 10 && !resp1_valid; c++) begin
               @(posedge clock);
               #1;
            end
            for (int c = 0; c < 5; c++) begin
               chk("bp_resp1_valid", 64'(resp1_valid), 1);
               chk("bp_req0_ready", 64'(req0_ready), 0);
               @(posedge clock);
               #1;
            end
            want1 = 1'b1;
         end
      join
      chk("bp_grant_port", 64'(glog[glog.size()-1]), 0);
      chk("bp_grant_after_hs", 64'(gcyc[gcyc.size()-1]), 64'(hs_cyc[1] + 1));
      drain();

      // Both valid straight after reset: port 0 first.
      do_reset();
      fork
         issue(0, OpAdd, 32'd1, 32'd1, {32'd2, 1'b0, 1'b0});
         issue(1, OpSub, 32'd7, 32'd7, {32'd0, 1'b0, 1'b1});
      join
      drain();
      chk("both_grant_count", 64'(glog.size()), 2);
      chk("both_first", 64'(glog[0]), 0);
      chk("both_second", 64'(glog[1]), 1);

      // Fairness with both ports continuously valid.
      do_reset();
      fork
         for (int i = 0; i < 3; i++) issue(0, OpAdd, 32'(i), 32'd1, {32'(i + 1), 1'b0, 1'b0});
         for (int i = 0; i < 3; i++) issue(1, OpSub, 32'd10, 32'(i), {32'(10 - i), 1'b0, 1'b0});
      join
      drain();
      chk("rr_grant_count", 64'(glog.size()), 6);
      for (int i = 0; i < glog.size(); i++) begin
         chk("rr_order", 64'(glog[i]), 64'(i % 2));
         if (i > 0) chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 3);
      end

      // Reset during EXEC drops the operation and clears prio.
      issue(0, OpAdd, 32'd1, 32'd2, {32'd3, 1'b0, 1'b0});
      drain();
      issue(0, OpAdd, 32'd4, 32'd4, {32'd8, 1'b0, 1'b0});
      do_reset();
      chk("mid_rst_resp0_valid", 64'(resp0_valid), 0);
      chk("mid_rst_resp1_valid", 64'(resp1_valid), 0);
      chk("mid_rst_alu_ops", {alu_src1, alu_src2}, 0);
      chk("mid_rst_result", {resp0_result, resp0_less, resp0_zero}, 0);
      fork
         issue(0, OpSub, 32'd5, 32'd6, {32'hFFFF_FFFF, 1'b1, 1'b0});
         issue(1, OpLtu, 32'd5, 32'd6, {32'd1, 1'b1, 1'b0});
      join
      drain();
      chk("mid_rst_prio_first", 64'(glog[0]), 0);

      // Randomized traffic with random response backpressure.
      rand_rdy = 1'b1;
      fork
         rand_port(0);
         rand_port(1);
      join
      rand_rdy = 1'b0;
      want0 = 1'b1;
      want1 = 1'b1;
      drain();
      repeat (10) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
